transfer_unit: RTL and testbench

TRANSFER_UNIT -- requirements
Module: transfer_unit

---
 rtl/transfer_unit.sv | 209 ++++++++++++++++++++
 tb/tb_transfer_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transfer_unit.sv
// Register-transfer sequencer datapath with a two-state memory handshake FSM.
// Optional WAIT timeout/abort is enabled by defining TRANSFER_TIMEOUT_EN.
module transfer_unit (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_transfer_cmd,
   input  logic       i_inc_pc,
   input  logic [1:0] i_inc_dec_sp,
   input  logic       i_sel_ap,
   input  logic       i_reset_ir,
   input  logic [7:0] i_alu_res,
   input  logic [7:0] i_in,
   output logic       o_mem_req,
   output logic       o_mem_we,
   output logic [7:0] o_mem_addr,
   output logic [7:0] o_mem_wdata,
   input  logic [7:0] i_mem_rdata,
   input  logic       i_mem_ack,
   output logic       o_stall,
   output logic [7:0] o_ir,
   output logic [7:0] o_a,
   output logic [7:0] o_ap,
   output logic [7:0] o_pc,
   output logic [7:0] o_sp,
   output logic [7:0] o_ma,
   output logic [7:0] o_md,
   output logic [7:0] o_out,
   output logic       o_out_valid,
   output logic       o_bus_error
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StWait = 1'b1;

   logic [7:0] ir_q, ir_d, a_q, a_d, ap_q, ap_d, pc_q, pc_d, sp_q, sp_d;
   logic [7:0] ma_q, ma_d, md_q, md_d, out_q, out_d, addr_q, addr_d, wdata_q, wdata_d;
   logic       out_valid_q, out_valid_d, we_q, we_d;
   logic [0:0] state_q, state_d;
   logic       mem_cmd, done, done_we, exec, inc_ok;
`ifdef TRANSFER_TIMEOUT_EN
   logic [3:0] cnt_q, cnt_d;
   logic       bus_error_q, bus_error_d;
`endif

   assign mem_cmd = (i_transfer_cmd == 4'h2) || (i_transfer_cmd == 4'h9);

   always_comb begin
      ir_d        = ir_q;
      a_d         = a_q;
      ap_d        = ap_q;
      pc_d        = pc_q;
      sp_d        = sp_q;
      ma_d        = ma_q;
      md_d        = md_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      state_d     = state_q;
      done        = 1'b0;
      done_we     = 1'b0;
      exec        = 1'b0;
      o_mem_req   = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = 8'h00;
      o_mem_wdata = 8'h00;
`ifdef TRANSFER_TIMEOUT_EN
      cnt_d       = cnt_q;
      bus_error_d = bus_error_q;
`endif

      case (state_q)
         StIdle: begin
            if (mem_cmd) begin
               o_mem_req   = 1'b1;
               o_mem_we    = (i_transfer_cmd == 4'h9);
               o_mem_addr  = ma_q;
               o_mem_wdata = md_q;
               if (i_mem_ack) begin
                  done    = 1'b1;
                  done_we = o_mem_we;
               end else begin
                  state_d = StWait;
                  we_d    = o_mem_we;
                  addr_d  = ma_q;
                  wdata_d = md_q;
`ifdef TRANSFER_TIMEOUT_EN
                  cnt_d   = 4'h0;
`endif
               end
            end else begin
               exec = 1'b1;
            end
         end
         default: begin
            // Sequencer inputs are ignored here; the request is replayed from the latched copy.
            o_mem_req   = 1'b1;
            o_mem_we    = we_q;
            o_mem_addr  = addr_q;
            o_mem_wdata = wdata_q;
            if (i_mem_ack) begin
               done    = 1'b1;
               done_we = we_q;
               state_d = StIdle;
            end
`ifdef TRANSFER_TIMEOUT_EN
            else if (cnt_q == 4'hF) begin
               state_d     = StIdle;
               bus_error_d = 1'b1;
               if (!we_q) md_d = 8'hFF;
            end else begin
               cnt_d = cnt_q + 4'h1;
            end
`endif
         end
      endcase

      inc_ok = exec || done;
      if (inc_ok && i_inc_pc) pc_d = pc_q + 8'h01;
      if (inc_ok && (i_inc_dec_sp == 2'b01)) sp_d = sp_q + 8'h01;
      if (inc_ok && (i_inc_dec_sp == 2'b10)) sp_d = sp_q - 8'h01;
      if (done && !done_we) md_d = i_mem_rdata;

      // Explicit PC writes come after the increment so they win.
      if (exec) begin
         case (i_transfer_cmd)
            4'h1: ma_d = pc_q;
            4'h3: ir_d = md_q;
            4'h4: ma_d = md_q;
            4'h5: if (i_sel_ap) ap_d = md_q; else a_d = md_q;
            4'h6: ma_d = ap_q;
            4'h7: ma_d = sp_q;
            4'h8: md_d = i_sel_ap ? ap_q : a_q;
            4'hA: if (i_sel_ap) ap_d = i_alu_res; else a_d = i_alu_res;
            4'hB: pc_d = md_q;
            4'hC: a_d = i_in;
            4'hD: begin
               out_d       = a_q;
               out_valid_d = 1'b1;
            end
            4'hE: pc_d = ap_q;
            4'hF: md_d = pc_q;
            default: ;
         endcase
      end
      if (i_reset_ir) ir_d = 8'h00;

      o_stall = o_mem_req && !done;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ir_q        <= 8'h00;
         a_q         <= 8'h00;
         ap_q        <= 8'h00;
         pc_q        <= 8'h00;
         sp_q        <= 8'h00;
         ma_q        <= 8'h00;
         md_q        <= 8'h00;
         out_q       <= 8'h00;
         out_valid_q <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 8'h00;
         wdata_q     <= 8'h00;
         state_q     <= StIdle;
      end else begin
         ir_q        <= ir_d;
         a_q         <= a_d;
         ap_q        <= ap_d;
         pc_q        <= pc_d;
         sp_q        <= sp_d;
         ma_q        <= ma_d;
         md_q        <= md_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         state_q     <= state_d;
      end
   end

`ifdef TRANSFER_TIMEOUT_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q       <= 4'h0;
         bus_error_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         bus_error_q <= bus_error_d;
      end
   end
   assign o_bus_error = bus_error_q;
`else
   assign o_bus_error = 1'b0;
`endif

   assign o_ir        = ir_q;
   assign o_a         = a_q;
   assign o_ap        = ap_q;
   assign o_pc        = pc_q;
   assign o_sp        = sp_q;
   assign o_ma        = ma_q;
   assign o_md        = md_q;
   assign o_out       = out_q;
   assign o_out_valid = out_valid_q;

endmodule

// File: tb/tb_transfer_unit.sv
// Directed self-checking bench for transfer_unit; timeout checks follow TRANSFER_TIMEOUT_EN.
module tb_transfer_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] cmd;
   logic       inc_pc, sel_ap, reset_ir, ack;
   logic [1:0] inc_sp;
   logic [7:0] alu, in_port, rdata;
   logic       mem_req, mem_we, stall, out_valid, bus_error;
   logic [7:0] mem_addr, mem_wdata, ir, a, ap, pc, sp, ma, md, out_r;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   transfer_unit dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_transfer_cmd (cmd),
      .i_inc_pc       (inc_pc),
      .i_inc_dec_sp   (inc_sp),
      .i_sel_ap       (sel_ap),
      .i_reset_ir     (reset_ir),
      .i_alu_res      (alu),
      .i_in           (in_port),
      .o_mem_req      (mem_req),
      .o_mem_we       (mem_we),
      .o_mem_addr     (mem_addr),
      .o_mem_wdata    (mem_wdata),
      .i_mem_rdata    (rdata),
      .i_mem_ack      (ack),
      .o_stall        (stall),
      .o_ir           (ir),
      .o_a            (a),
      .o_ap           (ap),
      .o_pc           (pc),
      .o_sp           (sp),
      .o_ma           (ma),
      .o_md           (md),
      .o_out          (out_r),
      .o_out_valid    (out_valid),
      .o_bus_error    (bus_error)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      cmd = 4'h0; inc_pc = 1'b0; inc_sp = 2'b00; sel_ap = 1'b0; reset_ir = 1'b0;
      alu = 8'h00; in_port = 8'h00; rdata = 8'h00; ack = 1'b0;
   endtask

   task automatic do_cmd(input logic [3:0] c, input logic [7:0] v);
      cmd = c; alu = v;
      step();
      clear_in();
   endtask

   task automatic test_reset();
      logic [7:0] regs [8];
      rst = 1'b1;
      clear_in();
      step();
      step();
      rst = 1'b0;
      regs = '{ir, a, ap, pc, sp, ma, md, out_r};
      for (int i = 0; i < 8; i++) begin
         tests_run++;
         if (regs[i] !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_reg%0d: got %h expected 00", i, regs[i]);
         end
      end
      tests_run++;
      if ({out_valid, bus_error, mem_req, stall} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b expected 0000", {out_valid, bus_error, mem_req, stall});
      end
   endtask

   task automatic test_read_zero_wait();
      do_cmd(4'h1, 8'h00);
      cmd = 4'h2; inc_pc = 1'b1; ack = 1'b1; rdata = 8'h3C;
      #1;
      tests_run++;
      if ({mem_req, mem_we, stall, mem_addr} !== {3'b100, 8'h00}) begin
         tests_failed++;
         $display("FAIL read0_handshake: got req/we/stall/addr %b%b%b/%h expected 100/00",
                  mem_req, mem_we, stall, mem_addr);
      end
      step();
      clear_in();
      tests_run++;
      if ({ma, md, pc} !== {8'h00, 8'h3C, 8'h01}) begin
         tests_failed++;
         $display("FAIL read0_regs: got ma/md/pc %h/%h/%h expected 00/3c/01", ma, md, pc);
      end
   endtask

   task automatic test_write_wait();
      int stall_cnt = 0;
      int bad_cnt   = 0;
      int wr_cnt    = 0;
      do_cmd(4'hA, 8'h10);
      do_cmd(4'h8, 8'h00);
      do_cmd(4'h4, 8'h00);
      do_cmd(4'hA, 8'hA5);
      do_cmd(4'h8, 8'h00);
      tests_run++;
      if ({ma, md} !== {8'h10, 8'hA5}) begin
         tests_failed++;
         $display("FAIL write_setup: got ma/md %h/%h expected 10/a5", ma, md);
      end
      cmd = 4'h9;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin cmd = 4'h1; inc_pc = 1'b1; inc_sp = 2'b01; end
         if (i == 3) begin cmd = 4'h9; inc_pc = 1'b0; inc_sp = 2'b00; ack = 1'b1; end
         #1;
         if (stall) stall_cnt++;
         if (!mem_req || mem_addr !== 8'h10 || mem_we !== 1'b1 || mem_wdata !== 8'hA5) bad_cnt++;
         if (mem_req && ack && mem_we && mem_wdata == 8'hA5 && mem_addr == 8'h10) wr_cnt++;
         step();
      end
      clear_in();
      #1;
      tests_run++;
      if (stall_cnt !== 3) begin
         tests_failed++;
         $display("FAIL write_stall_cycles: got %0d expected 3", stall_cnt);
      end
      tests_run++;
      if (bad_cnt !== 0 || wr_cnt !== 1) begin
         tests_failed++;
         $display("FAIL write_bus_hold: got bad=%0d writes=%0d expected 0/1", bad_cnt, wr_cnt);
      end
      tests_run++;
      if ({mem_req, pc, sp, ma} !== {1'b0, 8'h01, 8'h00, 8'h10}) begin
         tests_failed++;
         $display("FAIL write_wait_ignore: got req/pc/sp/ma %b/%h/%h/%h expected 0/01/00/10",
                  mem_req, pc, sp, ma);
      end
   endtask

   task automatic test_wrap();
      inc_sp = 2'b10;
      step();
      tests_run++;
      if (sp !== 8'hFF) begin
         tests_failed++;
         $display("FAIL sp_dec_wrap: got %h expected ff", sp);
      end
      inc_sp = 2'b01;
      step();
      clear_in();
      tests_run++;
      if (sp !== 8'h00) begin
         tests_failed++;
         $display("FAIL sp_inc_wrap: got %h expected 00", sp);
      end
      do_cmd(4'hA, 8'hFF);
      do_cmd(4'h8, 8'h00);
      cmd = 4'hB; inc_pc = 1'b1;
      step();
      tests_run++;
      if (pc !== 8'hFF) begin
         tests_failed++;
         $display("FAIL pc_write_priority: got %h expected ff", pc);
      end
      cmd = 4'h0;
      step();
      clear_in();
      tests_run++;
      if (pc !== 8'h00) begin
         tests_failed++;
         $display("FAIL pc_inc_wrap: got %h expected 00", pc);
      end
   endtask

   task automatic test_misc_cmds();
      sel_ap = 1'b1;
      do_cmd(4'hA, 8'h42);
      tests_run++;
      if ({a, ap} !== {8'hFF, 8'h42}) begin
         tests_failed++;
         $display("FAIL sel_ap_write: got a/ap %h/%h expected ff/42", a, ap);
      end
      do_cmd(4'h6, 8'h00);
      do_cmd(4'hE, 8'h00);
      do_cmd(4'hF, 8'h00);
      do_cmd(4'h3, 8'h00);
      tests_run++;
      if ({ma, pc, md, ir} !== {8'h42, 8'h42, 8'h42, 8'h42}) begin
         tests_failed++;
         $display("FAIL ap_path: got ma/pc/md/ir %h/%h/%h/%h expected 42/42/42/42", ma, pc, md, ir);
      end
      reset_ir = 1'b1;
      do_cmd(4'h3, 8'h00);
      tests_run++;
      if (ir !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_ir_priority: got %h expected 00", ir);
      end
      in_port = 8'h3E;
      do_cmd(4'hC, 8'h00);
      inc_sp = 2'b01;
      do_cmd(4'h0, 8'h00);
      do_cmd(4'h7, 8'h00);
      tests_run++;
      if ({a, sp, ma} !== {8'h3E, 8'h01, 8'h01}) begin
         tests_failed++;
         $display("FAIL in_sp_path: got a/sp/ma %h/%h/%h expected 3e/01/01", a, sp, ma);
      end
      ack = 1'b1; rdata = 8'h99;
      #1;
      tests_run++;
      if (mem_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_ack_req: got %b expected 0", mem_req);
      end
      step();
      clear_in();
      tests_run++;
      if (md !== 8'h42) begin
         tests_failed++;
         $display("FAIL idle_ack_ignored: got md %h expected 42", md);
      end
   endtask

   task automatic test_out();
      do_cmd(4'hA, 8'h5A);
      do_cmd(4'hD, 8'h00);
      tests_run++;
      if ({out_r, out_valid} !== {8'h5A, 1'b1}) begin
         tests_failed++;
         $display("FAIL out_write: got out/valid %h/%b expected 5a/1", out_r, out_valid);
      end
      step();
      tests_run++;
      if ({out_r, out_valid} !== {8'h5A, 1'b0}) begin
         tests_failed++;
         $display("FAIL out_valid_pulse: got out/valid %h/%b expected 5a/0", out_r, out_valid);
      end
   endtask

   task automatic test_reset_in_wait();
      rst = 1'b1;
      step();
      rst = 1'b0;
      cmd = 4'h2;
      step();
      tests_run++;
      if ({mem_req, stall} !== 2'b11) begin
         tests_failed++;
         $display("FAIL wait_entry: got req/stall %b%b expected 11", mem_req, stall);
      end
      rst = 1'b1;
      step();
      rst = 1'b0; cmd = 4'h0; ack = 1'b1; rdata = 8'h77;
      #1;
      tests_run++;
      if (mem_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_wait_req: got %b expected 0", mem_req);
      end
      step();
      clear_in();
      tests_run++;
      if ({md, stall} !== {8'h00, 1'b0}) begin
         tests_failed++;
         $display("FAIL rst_wait_stray_ack: got md/stall %h/%b expected 00/0", md, stall);
      end
   endtask

   task automatic test_timeout();
      int stall_cnt = 0;
      cmd = 4'h2;
      step();
      cmd = 4'h0; inc_pc = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (stall) stall_cnt++;
         step();
      end
      inc_pc = 1'b0;
      #1;
      tests_run++;
      if (stall_cnt !== 16) begin
         tests_failed++;
         $display("FAIL timeout_wait_stall: got %0d expected 16", stall_cnt);
      end
`ifdef TRANSFER_TIMEOUT_EN
      tests_run++;
      if ({md, bus_error, stall, pc} !== {8'hFF, 1'b1, 1'b0, 8'h00}) begin
         tests_failed++;
         $display("FAIL timeout_abort: got md/err/stall/pc %h/%b/%b/%h expected ff/1/0/00",
                  md, bus_error, stall, pc);
      end
      step();
      tests_run++;
      if (bus_error !== 1'b1) begin
         tests_failed++;
         $display("FAIL bus_error_sticky: got %b expected 1", bus_error);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests_run++;
      if (bus_error !== 1'b0) begin
         tests_failed++;
         $display("FAIL bus_error_reset: got %b expected 0", bus_error);
      end
`else
      tests_run++;
      if ({md, bus_error, stall} !== {8'h00, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL no_timeout_wait: got md/err/stall %h/%b/%b expected 00/0/1",
                  md, bus_error, stall);
      end
      ack = 1'b1; rdata = 8'h11; inc_pc = 1'b1;
      step();
      clear_in();
      tests_run++;
      if ({md, pc, stall} !== {8'h11, 8'h01, 1'b0}) begin
         tests_failed++;
         $display("FAIL late_ack_complete: got md/pc/stall %h/%h/%b expected 11/01/0",
                  md, pc, stall);
      end
`endif
      clear_in();
   endtask

   initial begin
      rst = 1'b1;
      clear_in();
      test_reset();
      test_read_zero_wait();
      test_write_wait();
      test_wrap();
      test_misc_cmds();
      test_out();
      test_reset_in_wait();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
